// File: rtl/mm_dma_copy.sv
// Memory-mapped DMA copy engine: moves len words from src_addr to dst_addr as a
// single-outstanding bus initiator, one read followed by one write per word.
module mm_dma_copy #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32,
    parameter int unsigned LW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   src_addr,
    input  logic [AW-1:0]   dst_addr,
    input  logic [LW-1:0]   len,
    output logic            busy,
    output logic            done,
    output logic            dma_req,
    output logic            dma_write,
    output logic [DW/8-1:0] dma_wstrb,
    output logic [AW-1:0]   dma_addr,
    output logic [DW-1:0]   dma_wdata,
    input  logic            dma_ready,
    input  logic            dma_rvalid,
    input  logic [DW-1:0]   dma_rdata
);
    localparam int unsigned   SW   = DW / 8;
    localparam logic [AW-1:0] STEP = AW'(SW);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;

    logic          busy_d, done_d, req_d, write_d;
    logic [SW-1:0] wstrb_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        cnt_d   = len;
                        state_d = RD_REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RD_REQ: begin
                if (dma_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (dma_rvalid) begin
                    data_d  = dma_rdata;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (dma_ready) begin
                    src_d   = src_q + STEP;
                    dst_d   = dst_q + STEP;
                    cnt_d   = cnt_q - LW'(1);
                    state_d = (cnt_q == LW'(1)) ? DONE : RD_REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs decoded from the upcoming state so they can be registered
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        req_d   = 1'b0;
        write_d = 1'b0;
        wstrb_d = '0;
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            RD_REQ: begin
                busy_d = 1'b1;
                req_d  = 1'b1;
                addr_d = src_d;
            end
            RD_WAIT: busy_d = 1'b1;
            WR_REQ: begin
                busy_d  = 1'b1;
                req_d   = 1'b1;
                write_d = 1'b1;
                wstrb_d = '1;
                addr_d  = dst_d;
                wdata_d = data_d;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            dma_req   <= 1'b0;
            dma_write <= 1'b0;
            dma_wstrb <= '0;
            dma_addr  <= '0;
            dma_wdata <= '0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            dma_req   <= req_d;
            dma_write <= write_d;
            dma_wstrb <= wstrb_d;
            dma_addr  <= addr_d;
            dma_wdata <= wdata_d;
        end
    end
endmodule

// File: doc/mm_dma_copy.md
MM_DMA_COPY -- requirements
Module: mm_dma_copy

Interface
REQ-001 Parameter AW, default 12, is the memory-mapped address width in bits.
REQ-002 Parameter DW, default 32, is the data width in bits and is a multiple of 8.
REQ-003 Parameter LW, default 8, is the transfer-length counter width in bits.
REQ-004 clk  input  1  is the single clock, and all logic is clocked on its rising edge.
REQ-005 rst  input  1  is the reset, which is asynchronous and active-high.
REQ-006 start  input  1  is a one-cycle pulse that launches a copy.
REQ-007 src_addr  input  AW  is the byte address of the first source word.
REQ-008 dst_addr  input  AW  is the byte address of the first destination word.
REQ-009 len  input  LW  is the number of DW-bit words to copy.
REQ-010 busy  output  1  is high while a copy is in progress.
REQ-011 done  output  1  is a one-cycle pulse marking copy completion.
REQ-012 dma_req  output  1  is the bus request.
REQ-013 dma_write  output  1  selects a write when 1 and a read when 0.
REQ-014 dma_wstrb  output  DW/8  is the byte-enable field.
REQ-015 dma_addr  output  AW  is the byte address of the request.
REQ-016 dma_wdata  output  DW  is the write data.
REQ-017 dma_ready  input  1  is the responder's acceptance signal.
REQ-018 dma_rvalid  input  1  is the read-data-valid strobe.
REQ-019 dma_rdata  input  DW  is the read data.

Function
REQ-020 The block SHALL act as bus initiator: a request transfers on the cycle dma_req and dma_ready are both high, and dma_req, dma_write, dma_addr, dma_wdata and dma_wstrb SHALL hold stable until that cycle.
REQ-021 The block SHALL use states IDLE, RD_REQ, RD_WAIT, WR_REQ and DONE.
REQ-022 IDLE: start=1 with len!=0 SHALL latch src_addr, dst_addr and len into internal registers and move to RD_REQ on the next cycle.
REQ-023 IDLE: start=1 with len=0 SHALL move to DONE with no bus request issued.
REQ-024 RD_REQ: dma_req=1 and dma_write=0 at the current source address; on acceptance the block SHALL move to RD_WAIT.
REQ-025 RD_WAIT: dma_req=0; on the first dma_rvalid=1 the block SHALL capture dma_rdata into a data register and move to WR_REQ, and dma_rvalid may arrive 1 or more cycles after acceptance.
REQ-026 WR_REQ: dma_req=1, dma_write=1 and dma_wstrb all ones, with dma_wdata set to the captured word at the current destination address.
REQ-027 WR_REQ on acceptance: both addresses SHALL increment by DW/8 and the remaining count SHALL decrement by 1, then the block SHALL go to RD_REQ if the count is still nonzero, otherwise to DONE.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 busy SHALL be 1 in RD_REQ, RD_WAIT and WR_REQ, and 0 in IDLE and DONE.
REQ-030 Address arithmetic SHALL be modulo 2^AW, so the address wraps from 2^AW-DW/8 to 0.
REQ-031 At most one read SHALL be outstanding, and no new request SHALL issue while in RD_WAIT.
REQ-032 start SHALL be ignored outside IDLE, including in DONE.
REQ-033 dma_rvalid SHALL be ignored outside RD_WAIT.
REQ-034 dma_ready SHALL be ignored while dma_req=0.
REQ-035 dma_wstrb SHALL be 0 and dma_wdata don't-care whenever dma_write=0.
REQ-036 The block SHALL complete len reads and len writes in strictly alternating order, read first.
REQ-037 With ready and rvalid both tied to 1, each word SHALL take 3 cycles (RD_REQ, RD_WAIT, WR_REQ).

Reset
REQ-038 Asserting rst SHALL asynchronously force IDLE and set busy, done, dma_req and dma_write to 0, with dma_addr, dma_wdata, dma_wstrb, the counter and the data register all at 0.
REQ-039 rst asserted mid-copy SHALL abort the copy with no done pulse.
REQ-040 After rst releases, the block SHALL issue no bus request until a new start.

Verification
REQ-041 Scenario: src=0x100, dst=0x200, len=3, ready=1, rvalid one cycle after acceptance -> reads at 0x100/0x104/0x108 and writes at 0x200/0x204/0x208 carrying the returned data, done pulses once, busy high 9 cycles.
REQ-042 Scenario: len=0 start -> no dma_req, done pulses the cycle after start, busy stays 0.
REQ-043 Scenario: ready held low 4 cycles during a WR_REQ -> dma_addr and dma_wdata stay stable, only one write occurs, and the count decrements once.
REQ-044 Scenario: src=0xFFC, len=2, AW=12 -> second read at 0x000.
REQ-045 Scenario: start pulsed while busy, and a spurious rvalid in IDLE -> no effect on addresses, count or done.
REQ-046 Scenario: rst asserted in RD_WAIT -> dma_req=0 and busy=0 immediately, with no done; a following rvalid is ignored, and a new start runs correctly.
